// File: rtl/fsm_table_sequencer_pkg.sv
// Shared definitions for the table-driven FSM sequencer.
//   ctrl_t      : controller state encoding (IDLE/PRIME/RUN/DONE)
//   DEF_*       : default widths and start state used by the top module
package fsm_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_t;

  localparam int unsigned DEF_SW      = 3;
  localparam int unsigned DEF_OW      = 3;
  localparam int unsigned DEF_CW      = 8;
  localparam int unsigned DEF_INIT_ST = 2;

endpackage

// File: rtl/fsm_table_ram.sv
// Transition table storage: 2**AW x DW, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : read data for raddr
module fsm_table_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_table_sequencer.sv
// Controller for a runtime-loaded, table-driven Moore FSM.
// Table entry at {state,a} holds {next_state, out_of_state}.
//   clk, reset          : clock, synchronous active-high reset
//   cfg_we/addr/wdata   : table write port (accepted only in IDLE)
//   start, run_len      : begin a run of run_len steps (0 = until abort)
//   abort               : end the current run
//   a_valid, a, a_ready : input symbol handshake
//   out, out_valid      : output code of the current FSM state
//   busy, done          : controller not idle / run-complete pulse
//   step_cnt            : symbols accepted in current/last run
//   cfg_err             : sticky flag for table writes attempted while busy
module fsm_table_sequencer
  import fsm_table_sequencer_pkg::*;
#(
  parameter int unsigned SW      = DEF_SW,
  parameter int unsigned OW      = DEF_OW,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned INIT_ST = DEF_INIT_ST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [SW:0]     cfg_addr,
  input  logic [SW+OW-1:0] cfg_wdata,
  input  logic            start,
  input  logic [CW-1:0]   run_len,
  input  logic            abort,
  input  logic            a_valid,
  input  logic            a,
  output logic            a_ready,
  output logic [OW-1:0]   out,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   step_cnt,
  output logic            cfg_err
);

  localparam logic [SW-1:0] INIT = SW'(INIT_ST);

  ctrl_t           ctrl, ctrl_nxt;
  logic [SW-1:0]   fsm_state;
  logic [CW-1:0]   run_len_r;
  logic [CW-1:0]   step_inc;
  logic            wr_en;
  logic            accept;
  logic [SW:0]     rd0_addr, rd1_addr;
  logic [SW+OW-1:0] rd0_data, rd1_data;
  logic [SW-1:0]   nxt_state;
  logic [OW-1:0]   nxt_out;
  logic            unused_bits;

  assign wr_en = cfg_we && (ctrl == IDLE);

  // Two identically-written table copies: the first resolves the transition,
  // the second chains off it to fetch the next state's output code in the
  // same cycle (output lookup is always at {state,0}).
  assign rd0_addr  = {fsm_state, a};
  assign nxt_state = rd0_data[SW+OW-1 -: SW];
  assign rd1_addr  = (ctrl == PRIME) ? {INIT, 1'b0} : {nxt_state, 1'b0};
  assign nxt_out   = rd1_data[OW-1:0];
  assign unused_bits = ^{rd0_data[OW-1:0], rd1_data[SW+OW-1 -: SW]};

  fsm_table_ram #(.AW(SW+1), .DW(SW+OW)) u_tbl_next (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd0_addr),
    .rdata (rd0_data)
  );

  fsm_table_ram #(.AW(SW+1), .DW(SW+OW)) u_tbl_out (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd1_addr),
    .rdata (rd1_data)
  );

  // abort suppresses the accept so a same-cycle final symbol is not counted
  assign accept   = (ctrl == RUN) && a_valid && !abort;
  assign step_inc = step_cnt + CW'(1);

  always_comb begin
    ctrl_nxt = ctrl;
    unique case (ctrl)
      IDLE:  if (start) ctrl_nxt = PRIME;
      PRIME: ctrl_nxt = abort ? DONE : RUN;
      RUN: begin
        if (abort)
          ctrl_nxt = DONE;
        else if (accept && (run_len_r != '0) && (step_inc == run_len_r))
          ctrl_nxt = DONE;
      end
      DONE:  ctrl_nxt = IDLE;
      default: ctrl_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= IDLE;
      fsm_state <= INIT;
      out       <= '0;
      step_cnt  <= '0;
      run_len_r <= '0;
      cfg_err   <= 1'b0;
    end else begin
      ctrl <= ctrl_nxt;
      if (cfg_we && (ctrl != IDLE)) cfg_err <= 1'b1;
      if ((ctrl == IDLE) && start) begin
        run_len_r <= run_len;
        step_cnt  <= '0;
        fsm_state <= INIT;
        cfg_err   <= 1'b0;
      end
      if (ctrl == PRIME) out <= nxt_out;
      if (accept) begin
        fsm_state <= nxt_state;
        out       <= nxt_out;
        step_cnt  <= step_inc;
      end
    end
  end

  assign a_ready   = (ctrl == RUN);
  assign out_valid = (ctrl == RUN);
  assign busy      = (ctrl != IDLE);
  assign done      = (ctrl == DONE);

endmodule
